// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-decode handshake, decode-to-execute control bundle and status, seen from both sides.
// master = the decode stage itself; slave = the fetch/execute environment driving it.
interface decode_stage_pipe_if #(
    parameter int CNT_W = 8
);
    logic [31:0]      i_instr;
    logic             i_instr_vld;
    logic             o_instr_rdy;
    logic             i_flush;
    logic             o_ctrl_vld;
    logic             i_ctrl_rdy;
    logic [31:0]      o_instr;
    logic             o_pc_sel;
    logic             o_br_unsigned;
    logic             o_rd_wren_I;
    logic             o_op_a_sel;
    logic             o_op_b_sel;
    logic             o_mem_wren;
    logic             o_lsu_sel;
    logic             o_rd_wren_F;
    logic             o_reg_sel;
    logic [4:0]       o_alu_op;
    logic [2:0]       o_func;
    logic [2:0]       o_wb_sel;
    logic             o_insn_vld;
    logic             o_fp_busy;
    logic [CNT_W-1:0] o_illegal_cnt;

    modport master (
        input  i_instr, i_instr_vld, i_flush, i_ctrl_rdy,
        output o_instr_rdy, o_ctrl_vld, o_instr, o_pc_sel, o_br_unsigned, o_rd_wren_I,
               o_op_a_sel, o_op_b_sel, o_mem_wren, o_lsu_sel, o_rd_wren_F, o_reg_sel,
               o_alu_op, o_func, o_wb_sel, o_insn_vld, o_fp_busy, o_illegal_cnt
    );

    modport slave (
        output i_instr, i_instr_vld, i_flush, i_ctrl_rdy,
        input  o_instr_rdy, o_ctrl_vld, o_instr, o_pc_sel, o_br_unsigned, o_rd_wren_I,
               o_op_a_sel, o_op_b_sel, o_mem_wren, o_lsu_sel, o_rd_wren_F, o_reg_sel,
               o_alu_op, o_func, o_wb_sel, o_insn_vld, o_fp_busy, o_illegal_cnt
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I(+F) decode into one pipeline register; 1-cycle latency, no bubble under full flow.
// Ready drops while the held bundle is stalled by execute, an FP divide/sqrt is busy, or on flush.
module decode_stage_pipe #(
    parameter bit EN_F     = 1'b1,
    parameter int FDIV_LAT = 16,
    parameter int CNT_W    = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    decode_stage_pipe_if.master pipe_if
);
    typedef struct packed {
        logic       pc_sel, br_unsigned, rd_wren_i, op_a_sel, op_b_sel;
        logic       mem_wren, lsu_sel, rd_wren_f, reg_sel;
        logic [4:0] alu_op;
        logic [2:0] func;
        logic [2:0] wb_sel;
        logic       insn_vld;
    } ctrl_t;

    localparam ctrl_t CTRL_SAFE = {9'b0, 5'd0, 3'b111, 3'b000, 1'b1};
    localparam int    BW        = (FDIV_LAT > 0) ? $clog2(FDIV_LAT + 1) : 1;

    localparam logic [4:0] OPC_LOAD  = 5'b00000, OPC_FLW    = 5'b00001, OPC_OPIMM = 5'b00100,
                           OPC_AUIPC = 5'b00101, OPC_STORE  = 5'b01000, OPC_FSW   = 5'b01001,
                           OPC_OP    = 5'b01100, OPC_LUI    = 5'b01101, OPC_OPFP  = 5'b10100,
                           OPC_BR    = 5'b11000, OPC_JALR   = 5'b11001, OPC_JAL   = 5'b11011;

    function automatic logic [4:0] alu_int(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_int = alt ? 5'd1 : 5'd0;
            3'b001:  alu_int = 5'd7;
            3'b010:  alu_int = 5'd2;
            3'b011:  alu_int = 5'd3;
            3'b100:  alu_int = 5'd4;
            3'b101:  alu_int = alt ? 5'd9 : 5'd8;
            3'b110:  alu_int = 5'd5;
            default: alu_int = 5'd6;
        endcase
    endfunction

    ctrl_t            dec, ctrl_q, ctrl_d;
    logic             legal, accept, long_fp, fp_busy;
    logic [31:0]      ins, instr_q, instr_d;
    logic             vld_q, vld_d;
    logic [BW-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       f5;

    assign ins = pipe_if.i_instr;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];
    assign f5  = ins[31:27];

    always_comb begin
        dec   = CTRL_SAFE;
        legal = 1'b0;
        if (ins == 32'h0) begin
            legal = 1'b1;
        end else if (ins[1:0] == 2'b11) begin
            case (ins[6:2])
                OPC_OP: begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                    dec.rd_wren_i = 1'b1; dec.wb_sel = 3'b001; dec.alu_op = alu_int(f3, f7[5]);
                end
                OPC_OPIMM: begin
                    legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                            (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                    dec.rd_wren_i = 1'b1; dec.op_b_sel = 1'b1; dec.wb_sel = 3'b001;
                    dec.alu_op = alu_int(f3, (f3 == 3'b101) && f7[5]);
                end
                OPC_LOAD: begin
                    legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                    dec.rd_wren_i = 1'b1; dec.op_b_sel = 1'b1; dec.wb_sel = 3'b010; dec.func = f3;
                end
                OPC_STORE: begin
                    legal = (f3 <= 3'b010);
                    dec.mem_wren = 1'b1; dec.op_b_sel = 1'b1; dec.func = f3;
                end
                OPC_BR: begin
                    legal = (f3 != 3'b010) && (f3 != 3'b011);
                    dec.pc_sel = 1'b1; dec.op_a_sel = 1'b1; dec.op_b_sel = 1'b1;
                    dec.br_unsigned = (f3[2:1] == 2'b11);
                end
                OPC_JAL, OPC_JALR: begin
                    legal = (ins[6:2] == OPC_JAL) || (f3 == 3'b000);
                    dec.pc_sel = 1'b1; dec.rd_wren_i = 1'b1; dec.op_b_sel = 1'b1;
                    dec.op_a_sel = (ins[6:2] == OPC_JAL);
                end
                OPC_LUI, OPC_AUIPC: begin
                    legal = 1'b1;
                    dec.rd_wren_i = 1'b1; dec.op_b_sel = 1'b1; dec.wb_sel = 3'b001;
                    dec.op_a_sel = (ins[6:2] == OPC_AUIPC);
                    dec.alu_op = (ins[6:2] == OPC_LUI) ? 5'd15 : 5'd14;
                end
                OPC_FLW: if (EN_F) begin
                    legal = (f3 == 3'b010);
                    dec.op_b_sel = 1'b1; dec.func = 3'b010; dec.wb_sel = 3'b010;
                    dec.rd_wren_f = 1'b1; dec.reg_sel = 1'b1;
                end
                OPC_FSW: if (EN_F) begin
                    legal = (f3 == 3'b010);
                    dec.op_b_sel = 1'b1; dec.mem_wren = 1'b1; dec.func = 3'b010; dec.lsu_sel = 1'b1;
                end
                OPC_OPFP: if (EN_F) begin
                    // Default is an F-register result; compares/converts to int override below
                    dec.rd_wren_f = 1'b1; dec.reg_sel = 1'b1; dec.wb_sel = 3'b001;
                    case (f5)
                        5'b00000: begin legal = 1'b1; dec.alu_op = 5'd10; end
                        5'b00001: begin legal = 1'b1; dec.alu_op = 5'd11; end
                        5'b00010: begin legal = 1'b1; dec.alu_op = 5'd12; end
                        5'b00011: begin legal = 1'b1; dec.alu_op = 5'd13; end
                        5'b01011: begin legal = 1'b1; dec.alu_op = 5'd16; end
                        5'b00100: begin legal = (f3 <= 3'b010); dec.alu_op = 5'd17 + {2'b00, f3}; end
                        5'b00101: begin legal = (f3 <= 3'b001); dec.alu_op = 5'd20 + {2'b00, f3}; end
                        5'b11010: begin legal = 1'b1; dec.alu_op = ins[20] ? 5'd26 : 5'd25; end
                        5'b11110: begin legal = (f3 == 3'b000); dec.wb_sel = 3'b011; end
                        5'b11000, 5'b10100, 5'b11100: begin
                            dec.rd_wren_f = 1'b0; dec.reg_sel = 1'b0; dec.rd_wren_i = 1'b1;
                            if (f5 == 5'b11000) begin
                                legal = 1'b1; dec.alu_op = ins[20] ? 5'd23 : 5'd22;
                            end else if (f5 == 5'b10100) begin
                                legal = (f3 <= 3'b010); dec.alu_op = 5'd27 + {2'b00, f3};
                            end else begin
                                legal = (f3 <= 3'b001);
                                if (f3 == 3'b000) dec.wb_sel = 3'b100;
                                else dec.alu_op = 5'd24;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        if (!legal) dec = CTRL_SAFE;
        dec.insn_vld = legal;
    end

    assign fp_busy             = (busy_q != '0);
    assign long_fp             = (dec.alu_op == 5'd13) || (dec.alu_op == 5'd16);
    assign pipe_if.o_instr_rdy = !pipe_if.i_flush && !fp_busy && (!vld_q || pipe_if.i_ctrl_rdy);
    assign accept              = pipe_if.i_instr_vld && pipe_if.o_instr_rdy;

    always_comb begin
        vld_d   = vld_q;
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        if (fp_busy) busy_d = busy_q - BW'(1);
        if (pipe_if.i_flush) begin
            vld_d  = 1'b0;
            busy_d = '0;
        end else if (accept) begin
            vld_d   = 1'b1;
            ctrl_d  = dec;
            instr_d = ins;
            if (long_fp && FDIV_LAT > 0) busy_d = BW'(FDIV_LAT);
            if (!dec.insn_vld && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (pipe_if.i_ctrl_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q   <= 1'b0;
            ctrl_q  <= CTRL_SAFE;
            instr_q <= '0;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pipe_if.o_ctrl_vld    = vld_q;
    assign pipe_if.o_instr       = instr_q;
    assign pipe_if.o_pc_sel      = ctrl_q.pc_sel;
    assign pipe_if.o_br_unsigned = ctrl_q.br_unsigned;
    assign pipe_if.o_rd_wren_I   = ctrl_q.rd_wren_i;
    assign pipe_if.o_op_a_sel    = ctrl_q.op_a_sel;
    assign pipe_if.o_op_b_sel    = ctrl_q.op_b_sel;
    assign pipe_if.o_mem_wren    = ctrl_q.mem_wren;
    assign pipe_if.o_lsu_sel     = ctrl_q.lsu_sel;
    assign pipe_if.o_rd_wren_F   = ctrl_q.rd_wren_f;
    assign pipe_if.o_reg_sel     = ctrl_q.reg_sel;
    assign pipe_if.o_alu_op      = ctrl_q.alu_op;
    assign pipe_if.o_func        = ctrl_q.func;
    assign pipe_if.o_wb_sel      = ctrl_q.wb_sel;
    assign pipe_if.o_insn_vld    = ctrl_q.insn_vld;
    assign pipe_if.o_fp_busy     = fp_busy;
    assign pipe_if.o_illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench: decode vector table on the main instance, plus handshake, FP stall, flush,
// EN_F=0, narrow-counter saturation and asynchronous-reset sequences.
module tb_decode_stage_pipe;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] FDIV = 32'h1820F1D3;
    localparam logic [31:0] FADD = 32'h002081D3;

    typedef struct {
        logic [31:0] instr;
        logic [8:0]  flags;   // pc, br_uns, rdI, opa, opb, memw, lsu, rdF, reg_sel
        logic [4:0]  alu;
        logic [2:0]  func;
        logic [2:0]  wb;
        logic        iv;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        vld_m = 1'b0, vld_nf = 1'b0, vld_c2 = 1'b0, flush = 1'b0, ctrl_rdy = 1'b0;
    int          n_chk = 0, n_fail = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.CNT_W(8)) m_if ();
    decode_stage_pipe_if #(.CNT_W(8)) nf_if ();
    decode_stage_pipe_if #(.CNT_W(2)) c2_if ();

    assign m_if.i_instr  = instr;  assign m_if.i_instr_vld  = vld_m;
    assign m_if.i_flush  = flush;  assign m_if.i_ctrl_rdy   = ctrl_rdy;
    assign nf_if.i_instr = instr;  assign nf_if.i_instr_vld = vld_nf;
    assign nf_if.i_flush = flush;  assign nf_if.i_ctrl_rdy  = ctrl_rdy;
    assign c2_if.i_instr = instr;  assign c2_if.i_instr_vld = vld_c2;
    assign c2_if.i_flush = flush;  assign c2_if.i_ctrl_rdy  = ctrl_rdy;

    decode_stage_pipe #(.EN_F(1'b1), .FDIV_LAT(4), .CNT_W(8)) u_dut (.i_clk(clk), .i_rst_n(rst_n), .pipe_if(m_if));
    decode_stage_pipe #(.EN_F(1'b0), .FDIV_LAT(4), .CNT_W(8)) u_nf  (.i_clk(clk), .i_rst_n(rst_n), .pipe_if(nf_if));
    decode_stage_pipe #(.EN_F(1'b1), .FDIV_LAT(4), .CNT_W(2)) u_c2  (.i_clk(clk), .i_rst_n(rst_n), .pipe_if(c2_if));

    logic [8:0] m_flags;
    assign m_flags = {m_if.o_pc_sel, m_if.o_br_unsigned, m_if.o_rd_wren_I, m_if.o_op_a_sel, m_if.o_op_b_sel,
                      m_if.o_mem_wren, m_if.o_lsu_sel, m_if.o_rd_wren_F, m_if.o_reg_sel};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input vec_t v);
        chk({tag, " flags"}, 32'(m_flags), 32'(v.flags));
        chk({tag, " alu"}, 32'(m_if.o_alu_op), 32'(v.alu));
        chk({tag, " func"}, 32'(m_if.o_func), 32'(v.func));
        chk({tag, " wb"}, 32'(m_if.o_wb_sel), 32'(v.wb));
        chk({tag, " insn_vld"}, 32'(m_if.o_insn_vld), 32'(v.iv));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[$];
        vec_t safe;
        vt.push_back('{32'h002081B3, 9'b001000000, 5'd0,  3'b111, 3'b001, 1'b1}); // ADD
        vt.push_back('{32'h402081B3, 9'b001000000, 5'd1,  3'b111, 3'b001, 1'b1}); // SUB
        vt.push_back('{32'h4020D1B3, 9'b001000000, 5'd9,  3'b111, 3'b001, 1'b1}); // SRA
        vt.push_back('{32'h402091B3, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // SLL f7=0x20
        vt.push_back('{32'h00500093, 9'b001010000, 5'd0,  3'b111, 3'b001, 1'b1}); // ADDI
        vt.push_back('{32'h4030D093, 9'b001010000, 5'd9,  3'b111, 3'b001, 1'b1}); // SRAI
        vt.push_back('{32'h40309093, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // SLLI f7=0x20
        vt.push_back('{32'h00812283, 9'b001010000, 5'd0,  3'b010, 3'b010, 1'b1}); // LW
        vt.push_back('{32'h00813283, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // load f3=011
        vt.push_back('{32'h00512423, 9'b000011000, 5'd0,  3'b010, 3'b000, 1'b1}); // SW
        vt.push_back('{32'h0020E063, 9'b110110000, 5'd0,  3'b111, 3'b000, 1'b1}); // BLTU
        vt.push_back('{32'h0020A063, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // branch f3=010
        vt.push_back('{32'h000000EF, 9'b101110000, 5'd0,  3'b111, 3'b000, 1'b1}); // JAL
        vt.push_back('{32'h000100E7, 9'b101010000, 5'd0,  3'b111, 3'b000, 1'b1}); // JALR
        vt.push_back('{32'h123450B7, 9'b001010000, 5'd15, 3'b111, 3'b001, 1'b1}); // LUI
        vt.push_back('{32'h00000097, 9'b001110000, 5'd14, 3'b111, 3'b001, 1'b1}); // AUIPC
        vt.push_back('{32'h00000000, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b1}); // NOP
        vt.push_back('{32'hFFFFFFFF, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0});
        vt.push_back('{32'h0000007F, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0});
        vt.push_back('{32'h002081B0, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // low bits 00
        vt.push_back('{32'h002081D3, 9'b000000011, 5'd10, 3'b111, 3'b001, 1'b1}); // FADD.S
        vt.push_back('{32'h2020A1D3, 9'b000000011, 5'd19, 3'b111, 3'b001, 1'b1}); // FSGNJX.S
        vt.push_back('{32'h2020B1D3, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // FSGNJ f3=011
        vt.push_back('{32'hA02091D3, 9'b001000000, 5'd28, 3'b111, 3'b001, 1'b1}); // FLT.S
        vt.push_back('{32'hC010F1D3, 9'b001000000, 5'd23, 3'b111, 3'b001, 1'b1}); // FCVT.WU.S
        vt.push_back('{32'hE00081D3, 9'b001000000, 5'd0,  3'b111, 3'b100, 1'b1}); // FMV.X.W
        vt.push_back('{32'hF00081D3, 9'b000000011, 5'd0,  3'b111, 3'b011, 1'b1}); // FMV.W.X
        vt.push_back('{32'h00412087, 9'b000010011, 5'd0,  3'b010, 3'b010, 1'b1}); // FLW
        vt.push_back('{32'h00112227, 9'b000011100, 5'd0,  3'b010, 3'b000, 1'b1}); // FSW
        vt.push_back('{32'h00413087, 9'b000000000, 5'd0,  3'b111, 3'b000, 1'b0}); // FLW f3=011
        vt.push_back('{32'hE00091D3, 9'b001000000, 5'd24, 3'b111, 3'b001, 1'b1}); // FCLASS.S
        safe = '{32'h0, 9'b0, 5'd0, 3'b111, 3'b000, 1'b1};

        #12;
        chk("rst ctrl_vld", 32'(m_if.o_ctrl_vld), 0);
        chk("rst fp_busy", 32'(m_if.o_fp_busy), 0);
        chk("rst cnt", 32'(m_if.o_illegal_cnt), 0);
        chk("rst instr", m_if.o_instr, 0);
        chk_bundle("rst", safe);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            cyc();
            instr = vt[i].instr; vld_m = 1'b1; ctrl_rdy = 1'b1;
            #1 chk($sformatf("v%0d rdy", i), 32'(m_if.o_instr_rdy), 1);
            cyc();
            vld_m = 1'b0;
            if (!vt[i].iv) exp_cnt++;
            #1;
            chk($sformatf("v%0d ctrl_vld", i), 32'(m_if.o_ctrl_vld), 1);
            chk($sformatf("v%0d instr", i), m_if.o_instr, vt[i].instr);
            chk($sformatf("v%0d cnt", i), 32'(m_if.o_illegal_cnt), 32'(exp_cnt));
            chk_bundle($sformatf("v%0d", i), vt[i]);
        end

        // Back-to-back ADDI stream, then execute stalls for 3 cycles
        for (int k = 0; k < 5; k++) begin
            cyc();
            instr = 32'h00000093 | (32'(k + 1) << 20); vld_m = 1'b1;
            if (k == 4) ctrl_rdy = 1'b0;
            #1;
            chk($sformatf("s%0d rdy", k), 32'(m_if.o_instr_rdy), (k == 4) ? 0 : 1);
            if (k > 0) begin
                chk($sformatf("s%0d vld", k), 32'(m_if.o_ctrl_vld), 1);
                chk($sformatf("s%0d instr", k), m_if.o_instr, 32'h00000093 | (32'(k) << 20));
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk($sformatf("hold%0d instr", k), m_if.o_instr, 32'h00400093);
            chk($sformatf("hold%0d vld", k), 32'(m_if.o_ctrl_vld), 1);
            chk($sformatf("hold%0d rdy", k), 32'(m_if.o_instr_rdy), 0);
        end
        ctrl_rdy = 1'b1;
        cyc();
        vld_m = 1'b0;
        #1 chk("stall release instr", m_if.o_instr, 32'h00500093);
        cyc();
        #1 chk("consume no accept", 32'(m_if.o_ctrl_vld), 0);

        // FDIV.S stall: 4 busy cycles, an ADD waits behind it
        instr = FDIV; vld_m = 1'b1;
        #1 chk("fdiv rdy", 32'(m_if.o_instr_rdy), 1);
        cyc();
        instr = ADD;
        #1;
        chk_bundle("fdiv", '{FDIV, 9'b000000011, 5'd13, 3'b111, 3'b001, 1'b1});
        chk("busy1", 32'(m_if.o_fp_busy), 1);
        chk("busy1 rdy", 32'(m_if.o_instr_rdy), 0);
        for (int b = 2; b <= 4; b++) begin
            cyc();
            #1;
            chk($sformatf("busy%0d", b), 32'(m_if.o_fp_busy), 1);
            chk($sformatf("busy%0d rdy", b), 32'(m_if.o_instr_rdy), 0);
        end
        chk("fdiv consumed", 32'(m_if.o_ctrl_vld), 0);
        cyc();
        #1;
        chk("busy end", 32'(m_if.o_fp_busy), 0);
        chk("busy end rdy", 32'(m_if.o_instr_rdy), 1);
        cyc();
        vld_m = 1'b0;
        #1 chk("after div instr", m_if.o_instr, ADD);

        // Flush in busy cycle 2 while execute holds the FDIV bundle
        cyc();
        instr = FDIV; vld_m = 1'b1;
        cyc();
        vld_m = 1'b0; ctrl_rdy = 1'b0;
        #1 chk("fl busy1", 32'(m_if.o_fp_busy), 1);
        cyc();
        flush = 1'b1; instr = ADD; vld_m = 1'b1;
        #1 chk("fl rdy", 32'(m_if.o_instr_rdy), 0);
        cyc();
        flush = 1'b0; vld_m = 1'b0;
        #1;
        chk("fl busy", 32'(m_if.o_fp_busy), 0);
        chk("fl ctrl_vld", 32'(m_if.o_ctrl_vld), 0);
        chk("fl rdy after", 32'(m_if.o_instr_rdy), 1);
        chk("fl cnt kept", 32'(m_if.o_illegal_cnt), 32'(exp_cnt));

        // EN_F=0 instance rejects FADD.S
        ctrl_rdy = 1'b1;
        cyc();
        instr = FADD; vld_nf = 1'b1;
        cyc();
        vld_nf = 1'b0;
        #1;
        chk("nf vld", 32'(nf_if.o_ctrl_vld), 1);
        chk("nf insn_vld", 32'(nf_if.o_insn_vld), 0);
        chk("nf rd_wren_F", 32'(nf_if.o_rd_wren_F), 0);
        chk("nf alu", 32'(nf_if.o_alu_op), 0);
        chk("nf cnt", 32'(nf_if.o_illegal_cnt), 1);

        // CNT_W=2 instance saturates at 3
        cyc();
        instr = 32'hFFFFFFFF; vld_c2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 4) vld_c2 = 1'b0;
            #1 chk($sformatf("c2 cnt%0d", k), 32'(c2_if.o_illegal_cnt), (k < 3) ? k + 1 : 3);
        end

        // Asynchronous reset with a held FDIV entry and busy counter running
        cyc();
        instr = FDIV; vld_m = 1'b1; ctrl_rdy = 1'b0;
        cyc();
        vld_m = 1'b0;
        #1;
        chk("pre-rst vld", 32'(m_if.o_ctrl_vld), 1);
        chk("pre-rst busy", 32'(m_if.o_fp_busy), 1);
        chk("pre-rst cnt", 32'(m_if.o_illegal_cnt), 32'(exp_cnt));
        rst_n = 1'b0;
        #1;
        chk("arst vld", 32'(m_if.o_ctrl_vld), 0);
        chk("arst busy", 32'(m_if.o_fp_busy), 0);
        chk("arst cnt", 32'(m_if.o_illegal_cnt), 0);
        chk("arst instr", m_if.o_instr, 0);
        chk("arst c2 cnt", 32'(c2_if.o_illegal_cnt), 0);
        chk_bundle("arst", safe);
        cyc();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
